cpu_sequencer: RTL

- Multi-cycle control sequencer for the single-bus RISC-V core.
- Steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB. Drives the enables of PC, IR, register file and ALU, plus the RAM bus strobes.
- Owns the shared address/data bus: fetch and load/store never overlap. It selects the bus address source and waits on the RAM ready handshake with a timeout.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/seq_wait_timer.sv | 35 +++
 rtl/cpu_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle sequencer: state codes, RV64I opcodes, op classes.
package cpu_pkg;

   typedef enum logic [2:0] {
      StFetch   = 3'd0,
      StDecode  = 3'd1,
      StExecute = 3'd2,
      StMem     = 3'd3,
      StWb      = 3'd4,
      StHalt    = 3'd5,
      StFault   = 3'd6
   } state_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [2:0] FUNCT3_BEQ = 3'b000;
   localparam logic [2:0] FUNCT3_BNE = 3'b001;

   typedef enum logic [2:0] {
      OpNone,
      OpLoad,
      OpStore,
      OpAlu,
      OpLui,
      OpBranch,
      OpJal,
      OpJalr
   } op_class_e;

endpackage

// File: rtl/seq_wait_timer.sv
// Bus wait counter: cleared on every state change, counts stalled FETCH/MEM cycles and flags
// the cycle on which the count has reached MEM_TIMEOUT-1.
module seq_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 5
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic inc_i,
   output logic timeout_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout_o = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB and
// owns the shared RAM bus, with a ready timeout that parks the core in a sticky FAULT state.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       alu_zero,
   input  logic       mem_ready,
   input  logic       halt_req,
   output logic       pc_en,
   output logic       pc_sign,
   output logic       ir_en,
   output logic       reg_en,
   output logic       reg_write,
   output logic       reg_in_dir,
   output logic       alu_en,
   output logic       ram_cs,
   output logic       ram_oe,
   output logic       ram_we,
   output logic       addr_sel,
   output logic [2:0] state,
   output logic       retired,
   output logic       fault
);

   state_e    state_q, state_d;
   op_class_e class_q, class_d;
   op_class_e decoded;
   logic      fault_q;
   logic      retire;
   logic      timeout;
   logic      bus_wait;

   always_comb begin
      unique case (opcode)
         OPC_LOAD:            decoded = OpLoad;
         OPC_STORE:           decoded = OpStore;
         OPC_OP, OPC_OPIMM:   decoded = OpAlu;
         OPC_LUI:             decoded = OpLui;
         OPC_BRANCH:          decoded = OpBranch;
         OPC_JAL:             decoded = OpJal;
         OPC_JALR:            decoded = OpJalr;
         default:             decoded = OpNone;
      endcase
   end

   always_comb begin
      state_d = state_q;
      class_d = class_q;
      retire  = 1'b0;
      unique case (state_q)
         StFetch: begin
            if (mem_ready) begin
               state_d = StDecode;
            end else if (timeout) begin
               state_d = StFault;
            end
         end
         StDecode: begin
            class_d = decoded;
            if (decoded == OpNone) begin
               state_d = StFault;
            end else if (decoded == OpBranch && funct3 != FUNCT3_BEQ
                         && funct3 != FUNCT3_BNE) begin
               state_d = StFault;
            end else begin
               state_d = StExecute;
            end
         end
         StExecute: begin
            unique case (class_q)
               OpLoad, OpStore:              state_d = StMem;
               OpAlu, OpLui, OpJal, OpJalr:  state_d = StWb;
               OpBranch:                     retire  = 1'b1;
               default:                      state_d = StFault;
            endcase
         end
         StMem: begin
            if (mem_ready) begin
               if (class_q == OpLoad) begin
                  state_d = StWb;
               end else begin
                  retire = 1'b1;
               end
            end else if (timeout) begin
               state_d = StFault;
            end
         end
         StWb:    retire = 1'b1;
         StHalt: begin
            if (!halt_req) begin
               state_d = StFetch;
            end
         end
         StFault: state_d = StFault;
         default: state_d = StFault;
      endcase
      // halt_req only matters on the cycle an instruction completes
      if (retire) begin
         state_d = halt_req ? StHalt : StFetch;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StFetch;
         class_q <= OpNone;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         class_q <= class_d;
         if (state_d == StFault) begin
            fault_q <= 1'b1;
         end
      end
   end

   assign bus_wait = (state_q == StFetch || state_q == StMem) && !mem_ready;

   seq_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_wait_timer (
      .clk_i     (clk),
      .reset_i   (reset),
      .clear_i   (state_d != state_q),
      .inc_i     (bus_wait),
      .timeout_o (timeout)
   );

   // Reset gates every output combinationally so bus strobes drop in the reset cycle itself.
   always_comb begin
      pc_en      = 1'b0;
      pc_sign    = 1'b0;
      ir_en      = 1'b0;
      reg_en     = 1'b0;
      reg_write  = 1'b0;
      reg_in_dir = 1'b0;
      alu_en     = 1'b0;
      ram_cs     = 1'b0;
      ram_oe     = 1'b0;
      ram_we     = 1'b0;
      addr_sel   = 1'b0;
      state      = 3'd0;
      retired    = 1'b0;
      fault      = 1'b0;
      if (!reset) begin
         state   = state_q;
         retired = retire;
         fault   = fault_q;
         unique case (state_q)
            StFetch: begin
               ram_cs = 1'b1;
               ram_oe = 1'b1;
               ir_en  = mem_ready;
            end
            StDecode: reg_en = 1'b1;
            StExecute: begin
               alu_en = 1'b1;
               reg_en = 1'b1;
               if (class_q == OpBranch) begin
                  pc_en   = 1'b1;
                  pc_sign = alu_zero ^ funct3[0];
               end
            end
            StMem: begin
               ram_cs   = 1'b1;
               addr_sel = 1'b1;
               reg_en   = 1'b1;
               ram_oe   = (class_q == OpLoad);
               ram_we   = (class_q == OpStore);
               pc_en    = (class_q == OpStore) && mem_ready;
            end
            StWb: begin
               reg_write  = 1'b1;
               pc_en      = 1'b1;
               reg_in_dir = (class_q == OpLoad);
               pc_sign    = (class_q == OpJal || class_q == OpJalr);
            end
            default: ;
         endcase
      end
   end

endmodule
